// File: rtl/error_recovery_unit_pkg.sv
// Shared types and constants for the error recovery unit: FSM state encoding,
// datapath widths and the per-vector base offsets of the lost-carry error terms.
package error_recovery_unit_pkg;

  localparam int PROD_W  = 32;
  localparam int ERR_W   = 16;
  localparam int NUM_VEC = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORR = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Base offsets for vectors i, j, k, l (index 0..3); each term lands one bit above its offset.
  localparam logic [NUM_VEC-1:0][4:0] ERR_OFFSET = {5'd15, 5'd11, 5'd7, 5'd3};

endpackage

// File: rtl/error_recovery_unit_shift_add.sv
// Combinational correction step: adds one error vector, shifted to its bit position,
// onto the accumulator (modulo 2^32).
module err_shift_add
  import error_recovery_unit_pkg::*;
(
  input  logic [PROD_W-1:0] acc,
  input  logic [ERR_W-1:0]  vec,
  input  logic [1:0]        idx,
  output logic [PROD_W-1:0] sum
);

  logic [4:0]        shamt;
  logic [PROD_W-1:0] term;

  assign shamt = ERR_OFFSET[idx] + 5'd1;
  assign term  = {{(PROD_W-ERR_W){1'b0}}, vec} << shamt;
  // Carry out of the top bit is intentionally dropped.
  assign sum   = acc + term;

endmodule

// File: rtl/error_recovery_unit.sv
// Error recovery unit: captures an approximate product plus four lost-carry vectors and
// folds NUM_CORR of them back in, one per cycle. Optional stats: ERR_RECOVERY_STATS_EN.
module error_recovery_unit
  import error_recovery_unit_pkg::*;
#(
  parameter int NUM_CORR = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] p_approx,
  input  logic [ERR_W-1:0]  err_i,
  input  logic [ERR_W-1:0]  err_j,
  input  logic [ERR_W-1:0]  err_k,
  input  logic [ERR_W-1:0]  err_l,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] p_out,
  output logic              busy
`ifdef ERR_RECOVERY_STATS_EN
  ,
  output logic [15:0]       corr_count,
  output logic              corr_flag
`endif
);

  localparam state_t     FIRST_STATE = (NUM_CORR > 0) ? CORR : HOLD;
  localparam logic [2:0] LAST_STEP   = 3'((NUM_CORR > 0) ? NUM_CORR - 1 : 0);

  state_t                          state_reg, state_next;
  logic [PROD_W-1:0]               acc_reg, acc_next;
  logic [2:0]                      step_reg, step_next;
  logic [NUM_VEC-1:0][ERR_W-1:0]   err_reg, err_next;
  logic [ERR_W-1:0]                cur_vec;
  logic [PROD_W-1:0]               acc_sum;

  assign cur_vec = err_reg[step_reg[1:0]];

  err_shift_add u_shift_add (
    .acc (acc_reg),
    .vec (cur_vec),
    .idx (step_reg[1:0]),
    .sum (acc_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      step_reg  <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      step_reg  <= step_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    step_next  = step_reg;
    err_next   = err_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    p_out      = '0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          acc_next   = p_approx;
          err_next   = {err_l, err_k, err_j, err_i};
          step_next  = '0;
          state_next = FIRST_STATE;
        end
      end
      CORR: begin
        acc_next  = acc_sum;
        step_next = step_reg + 3'd1;
        if (step_reg == LAST_STEP) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        p_out     = acc_reg;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ERR_RECOVERY_STATS_EN
  logic [15:0] count_reg;
  logic        flag_reg;
  logic        term_nonzero;

  assign term_nonzero = (state_reg == CORR) && (cur_vec != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      flag_reg  <= 1'b0;
    end else begin
      if (term_nonzero && (count_reg != 16'hFFFF)) count_reg <= count_reg + 16'd1;
      // Flag tracks only the operation in flight, so it restarts on each capture.
      if (state_reg == IDLE && in_valid) flag_reg <= 1'b0;
      else if (term_nonzero)              flag_reg <= 1'b1;
    end
  end

  assign corr_count = count_reg;
  assign corr_flag  = (state_reg == HOLD) && flag_reg;
`endif

endmodule

// File: tb/tb_error_recovery_unit.sv
// Directed testbench for error_recovery_unit: two instances (NUM_CORR=4 and 2) share stimulus;
// expected results are queued at drive time and popped when each DUT hands a result off.
module tb_error_recovery_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] p_approx = '0;
  logic [15:0] err_i = '0, err_j = '0, err_k = '0, err_l = '0;

  logic        in_ready4, out_valid4, busy4;
  logic [31:0] p_out4;
  logic        in_ready2, out_valid2, busy2;
  logic [31:0] p_out2;
`ifdef ERR_RECOVERY_STATS_EN
  logic [15:0] corr_count4, corr_count2;
  logic        corr_flag4, corr_flag2;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] q4[$];
  logic [31:0] q2[$];

  always #5 clk = ~clk;

  error_recovery_unit #(.NUM_CORR(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .p_approx(p_approx), .err_i(err_i), .err_j(err_j), .err_k(err_k), .err_l(err_l),
    .out_valid(out_valid4), .out_ready(out_ready), .p_out(p_out4), .busy(busy4)
`ifdef ERR_RECOVERY_STATS_EN
    , .corr_count(corr_count4), .corr_flag(corr_flag4)
`endif
  );

  error_recovery_unit #(.NUM_CORR(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .p_approx(p_approx), .err_i(err_i), .err_j(err_j), .err_k(err_k), .err_l(err_l),
    .out_valid(out_valid2), .out_ready(out_ready), .p_out(p_out2), .busy(busy2)
`ifdef ERR_RECOVERY_STATS_EN
    , .corr_count(corr_count2), .corr_flag(corr_flag2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
  endtask

  // Vector v (0..3) contributes v_value << (4*v + 4), summed modulo 2^32.
  function automatic logic [31:0] model(input logic [31:0] p, input logic [15:0] a, b, c, d,
                                        input int n);
    logic [15:0] v[4];
    logic [31:0] r;
    v = '{a, b, c, d};
    r = p;
    for (int k = 0; k < n; k++) r = r + ({16'h0, v[k]} << (4 * k + 4));
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid4 && out_ready) begin
      if (q4.size() == 0) check("dut4_unexpected_output", 32'd1, 32'd0);
      else begin
        $display("dut4 result p_out=0x%08h", p_out4);
        check("dut4_p_out", p_out4, q4.pop_front());
      end
    end
    if (rst_n && out_valid2 && out_ready) begin
      if (q2.size() == 0) check("dut2_unexpected_output", 32'd1, 32'd0);
      else begin
        $display("dut2 result p_out=0x%08h", p_out2);
        check("dut2_p_out", p_out2, q2.pop_front());
      end
    end
  end

  // Presents one operand set and returns #1 after the transfer edge.
  task automatic run_op(input logic [31:0] p, input logic [15:0] a, b, c, d, input bit push);
    if (push) begin
      q4.push_back(model(p, a, b, c, d, 4));
      q2.push_back(model(p, a, b, c, d, 2));
    end
    p_approx = p; err_i = a; err_j = b; err_k = c; err_l = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the transfer edge (edge 1) until out_valid is seen on each DUT.
  task automatic wait_result();
    int  c = 1;
    int  lat4 = -1;
    int  lat2 = -1;
    bit  seen4 = 0;
    bit  seen2 = 0;
    while (!seen4 && c <= 20) begin
      if (!seen2 && out_valid2) begin seen2 = 1; lat2 = c; end
      if (out_valid4) begin seen4 = 1; lat4 = c; end
      if (!seen4) begin @(posedge clk); #1; c++; end
    end
    check("latency4", lat4, 5);
    check("latency2", lat2, 3);
  endtask

  task automatic finish_handshake();
    @(posedge clk); #1;
    check("in_ready4_after_result", {31'd0, in_ready4}, 32'd1);
    check("in_ready2_after_result", {31'd0, in_ready2}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp_a;
    logic [31:0] exp_a2;
    int          guard;

    #2;
    check("reset_in_ready", {31'd0, in_ready4}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid4}, 32'd0);
    check("reset_busy", {31'd0, busy4}, 32'd0);
    check("reset_p_out", p_out4, 32'd0);
`ifdef ERR_RECOVERY_STATS_EN
    check("reset_corr_count", {16'd0, corr_count4}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(32'h0000_1000, 16'h0, 16'h0, 16'h0, 16'h0, 1);
    wait_result();
    finish_handshake();

    run_op(32'h0000_1000, 16'h1, 16'h1, 16'h1, 16'h1, 1);
    wait_result();
    finish_handshake();
`ifdef ERR_RECOVERY_STATS_EN
    check("corr_count4", {16'd0, corr_count4}, 32'd4);
    check("corr_count2", {16'd0, corr_count2}, 32'd2);
`endif

    run_op(32'hFFFF_0000, 16'h0, 16'h0, 16'h0, 16'hFFFF, 1);
    wait_result();
    finish_handshake();

    for (int n = 0; n < 3; n++) begin
      run_op($urandom, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1);
      wait_result();
      finish_handshake();
    end

    // Backpressure: result held while in_valid stays high with different operands.
    out_ready = 1'b0;
    exp_a  = model(32'h1234_5678, 16'h00AB, 16'h0CD0, 16'h1234, 16'hFFFF, 4);
    exp_a2 = model(32'h1234_5678, 16'h00AB, 16'h0CD0, 16'h1234, 16'hFFFF, 2);
    run_op(32'h1234_5678, 16'h00AB, 16'h0CD0, 16'h1234, 16'hFFFF, 1);
    in_valid = 1'b1;
    p_approx = 32'hA5A5_0000; err_i = 16'h0101; err_j = 16'h0202; err_k = 16'h0303; err_l = 16'h0404;
    guard = 0;
    while (!out_valid4 && guard < 20) begin @(posedge clk); #1; guard++; end
    check("bp_reached_hold", {31'd0, out_valid4}, 32'd1);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      check("bp_p_out4", p_out4, exp_a);
      check("bp_out_valid4", {31'd0, out_valid4}, 32'd1);
      check("bp_in_ready4", {31'd0, in_ready4}, 32'd0);
      check("bp_p_out2", p_out2, exp_a2);
    end
    q4.push_back(model(32'hA5A5_0000, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 4));
    q2.push_back(model(32'hA5A5_0000, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 2));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_in_ready4", {31'd0, in_ready4}, 32'd1);
    check("bp_idle_busy4", {31'd0, busy4}, 32'd0);
    @(posedge clk); #1;
    check("bp_new_accept4", {31'd0, busy4}, 32'd1);
    check("bp_new_accept2", {31'd0, busy2}, 32'd1);
    in_valid = 1'b0;
    wait_result();
    finish_handshake();

    // Reset during the second CORR cycle discards the operation.
    run_op(32'h0000_1000, 16'h1, 16'h1, 16'h1, 16'h1, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy_out_valid4", {31'd0, out_valid4}, 32'd0);
    check("rst_busy_busy4", {31'd0, busy4}, 32'd0);
    check("rst_busy_p_out4", p_out4, 32'd0);
    check("rst_busy_in_ready4", {31'd0, in_ready4}, 32'd1);
    check("rst_busy_busy2", {31'd0, busy2}, 32'd0);
`ifdef ERR_RECOVERY_STATS_EN
    check("rst_busy_corr_count4", {16'd0, corr_count4}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(32'h0000_1000, 16'h0, 16'h0, 16'h0, 16'h0, 1);
    wait_result();
    finish_handshake();

    check("q4_drained", q4.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
